// File: rtl/ariane_pkg.sv
// Shared constants for the ALU writeback skid buffer.
package ariane_pkg;

    localparam int unsigned ALU_WB_SKID_DEPTH = 2;

    // Pointer width for a power-of-two FIFO depth; at least one bit.
    function automatic int unsigned alu_wb_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/config_pkg.sv
// Core configuration type and the default configuration used by stand-alone builds.
package config_pkg;

    typedef struct packed {
        int unsigned NrALUs;
        int unsigned XLEN;
        int unsigned TRANS_ID_BITS;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{NrALUs: 2, XLEN: 32, TRANS_ID_BITS: 5};

endpackage

// File: rtl/alu_wb_lane_fifo.sv
// One in-order fall-through FIFO lane: storage, pointers, occupancy count and flush.
module alu_wb_lane_fifo
    import ariane_pkg::*;
#(
    parameter int unsigned Width = 37,
    parameter int unsigned Depth = ALU_WB_SKID_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_valid_i,
    input  logic [Width-1:0] push_data_i,
    output logic             push_ready_o,
    output logic             pop_valid_o,
    output logic [Width-1:0] pop_data_o,
    input  logic             pop_ready_i
);

    localparam int unsigned PtrW = alu_wb_ptr_w(Depth);
    localparam logic [PtrW:0] DepthCnt = Depth[PtrW:0];

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             empty, push, pop, write, head_pop;

    assign empty        = (count_q == '0);
    assign push_ready_o = (count_q < DepthCnt);
    assign push         = push_valid_i && push_ready_o;

    // Empty lane presents the incoming result directly.
    assign pop_valid_o = !flush_i && (empty ? push_valid_i : 1'b1);
    assign pop_data_o  = empty ? push_data_i : mem_q[rd_ptr_q];
    assign pop         = pop_valid_o && pop_ready_i;

    assign write    = push && !flush_i && !(empty && pop);
    assign head_pop = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (write) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
                count_d  = count_d + (PtrW + 1)'(1);
            end
            if (head_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
                count_d  = count_d - (PtrW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload is never cleared; only the count decides what is valid.
    always_ff @(posedge clk_i) begin
        if (write) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/alu_wb_skid.sv
// Per-lane ALU result skid buffer ahead of the scoreboard writeback ports.
// Define ALU_WB_SKID_PERF_EN to add per-lane saturating stall counters (stall_cnt_o).
module alu_wb_skid
    import ariane_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned           Depth   = ALU_WB_SKID_DEPTH
) (
    input  logic                                                   clk_i,
    input  logic                                                   rst_ni,
    input  logic                                                   flush_i,
    input  logic [CVA6Cfg.NrALUs-1:0]                              alu_valid_i,
    input  logic [CVA6Cfg.NrALUs-1:0][CVA6Cfg.TRANS_ID_BITS-1:0]   alu_trans_id_i,
    input  logic [CVA6Cfg.NrALUs-1:0][CVA6Cfg.XLEN-1:0]            alu_result_i,
    output logic [CVA6Cfg.NrALUs-1:0]                              alu_ready_o,
    output logic [CVA6Cfg.NrALUs-1:0]                              wb_valid_o,
    output logic [CVA6Cfg.NrALUs-1:0][CVA6Cfg.TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic [CVA6Cfg.NrALUs-1:0][CVA6Cfg.XLEN-1:0]            wb_result_o,
    input  logic [CVA6Cfg.NrALUs-1:0]                              wb_ready_i
`ifdef ALU_WB_SKID_PERF_EN
    ,
    output logic [CVA6Cfg.NrALUs-1:0][31:0]                        stall_cnt_o
`endif
);

    localparam int unsigned NrALUs = CVA6Cfg.NrALUs;

    typedef struct packed {
        logic [CVA6Cfg.TRANS_ID_BITS-1:0] trans_id;
        logic [CVA6Cfg.XLEN-1:0]          result;
    } alu_wb_entry_t;

    for (genvar l = 0; l < NrALUs; l++) begin : gen_lane
        alu_wb_entry_t push_entry, pop_entry;

        assign push_entry.trans_id = alu_trans_id_i[l];
        assign push_entry.result   = alu_result_i[l];

        alu_wb_lane_fifo #(
            .Width ($bits(alu_wb_entry_t)),
            .Depth (Depth)
        ) u_lane_fifo (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .flush_i      (flush_i),
            .push_valid_i (alu_valid_i[l]),
            .push_data_i  (push_entry),
            .push_ready_o (alu_ready_o[l]),
            .pop_valid_o  (wb_valid_o[l]),
            .pop_data_o   (pop_entry),
            .pop_ready_i  (wb_ready_i[l])
        );

        assign wb_trans_id_o[l] = pop_entry.trans_id;
        assign wb_result_o[l]   = pop_entry.result;

`ifdef ALU_WB_SKID_PERF_EN
        logic [31:0] stall_cnt_q;

        // Survives flush; saturates rather than wrapping.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stall_cnt_q <= '0;
            end else if (wb_valid_o[l] && !wb_ready_i[l] && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end

        assign stall_cnt_o[l] = stall_cnt_q;
`endif
    end

endmodule

// File: tb/tb_alu_wb_skid.sv
// Self-checking bench for alu_wb_skid: queue-based lane model plus directed literal checks.
module tb_alu_wb_skid;

    localparam int NR    = 2;
    localparam int XL    = 32;
    localparam int TW    = 5;
    localparam int DEPTH = 2;

    logic                    clk, rst_n, flush;
    logic [NR-1:0]           alu_valid, alu_ready, wb_valid, wb_ready;
    logic [NR-1:0][TW-1:0]   alu_tid, wb_tid;
    logic [NR-1:0][XL-1:0]   alu_res, wb_res;
`ifdef ALU_WB_SKID_PERF_EN
    logic [NR-1:0][31:0]     stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_wb_skid dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .alu_valid_i    (alu_valid),
        .alu_trans_id_i (alu_tid),
        .alu_result_i   (alu_res),
        .alu_ready_o    (alu_ready),
        .wb_valid_o     (wb_valid),
        .wb_trans_id_o  (wb_tid),
        .wb_result_o    (wb_res),
        .wb_ready_i     (wb_ready)
`ifdef ALU_WB_SKID_PERF_EN
        ,
        .stall_cnt_o    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one in-order queue of {tag, result} per lane.
    logic [TW+XL-1:0] q [NR][$];

    function automatic logic exp_valid(input int l);
        return !flush && (q[l].size() != 0 || alu_valid[l]);
    endfunction

    function automatic logic [TW+XL-1:0] exp_entry(input int l);
        if (q[l].size() != 0) return q[l][0];
        return {alu_tid[l], alu_res[l]};
    endfunction

    function automatic logic model_ready(input int l);
        return q[l].size() < DEPTH;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic do_push, do_pop;
        if (!rst_n) begin
            for (int l = 0; l < NR; l++) q[l].delete();
        end else begin
            for (int l = 0; l < NR; l++) begin
                do_push = alu_valid[l] && model_ready(l);
                do_pop  = exp_valid(l) && wb_ready[l];
                if (flush) begin
                    q[l].delete();
                end else begin
                    if (do_push) q[l].push_back({alu_tid[l], alu_res[l]});
                    if (do_pop) void'(q[l].pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [TW+XL-1:0] e;
        logic             ev;
        if (rst_n) begin
            for (int l = 0; l < NR; l++) begin
                ev = exp_valid(l);
                e  = exp_entry(l);
                check($sformatf("model lane%0d ready", l), 64'(alu_ready[l]), 64'(model_ready(l)));
                check($sformatf("model lane%0d valid", l), 64'(wb_valid[l]), 64'(ev));
                if (ev) begin
                    check($sformatf("model lane%0d tag", l), 64'(wb_tid[l]), 64'(e[TW+XL-1:XL]));
                    check($sformatf("model lane%0d result", l), 64'(wb_res[l]), 64'(e[XL-1:0]));
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && |(alu_valid & ~alu_ready)) $error("protocol: alu_valid while alu_ready low");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push(input int l, input int tag, input logic [XL-1:0] res);
        alu_valid[l] = 1'b1;
        alu_tid[l]   = TW'(tag);
        alu_res[l]   = res;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; alu_valid = '0; alu_tid = '0; alu_res = '0; wb_ready = '0;
        repeat (2) step();
        rst_n = 1'b1;
        sample();
        check("reset wb_valid", 64'(wb_valid), 64'h0);
        check("reset alu_ready", 64'(alu_ready), 64'h3);
        check("reset wb_trans_id", 64'(wb_tid), 64'h0);
        check("reset wb_result", 64'(wb_res), 64'h0);

        // Pass-through on an empty lane
        step(); wb_ready = 2'b11; push(0, 3, 32'hA5);
        sample();
        check("pass valid", 64'(wb_valid[0]), 64'h1);
        check("pass tag", 64'(wb_tid[0]), 64'd3);
        check("pass result", 64'(wb_res[0]), 64'hA5);
        step(); alu_valid = '0;
        sample();
        check("pass nothing stored", 64'(wb_valid[0]), 64'h0);

        // Fill and drain
        step(); wb_ready[0] = 1'b0; push(0, 1, 32'h11);
        sample(); check("fill first tag", 64'(wb_tid[0]), 64'd1);
        step(); push(0, 2, 32'h22);
        sample(); check("fill ready after one", 64'(alu_ready[0]), 64'h1);
        step(); alu_valid = '0;
        sample(); check("fill ready when full", 64'(alu_ready[0]), 64'h0);
        step(); wb_ready[0] = 1'b1;
        sample(); check("drain tag 1", 64'(wb_tid[0]), 64'd1);
        step();
        sample(); check("drain tag 2", 64'(wb_tid[0]), 64'd2);
        check("drain ready rose", 64'(alu_ready[0]), 64'h1);
        step();
        sample(); check("drain empty", 64'(wb_valid[0]), 64'h0);

        // Push and pop together
        step(); wb_ready[0] = 1'b0; push(0, 5, 32'h55);
        sample(); check("pp hold tag 5", 64'(wb_tid[0]), 64'd5);
        step(); push(0, 6, 32'h66); wb_ready[0] = 1'b1;
        sample(); check("pp head tag 5", 64'(wb_tid[0]), 64'd5);
        step(); alu_valid = '0; wb_ready[0] = 1'b0;
        sample(); check("pp next tag 6", 64'(wb_tid[0]), 64'd6);
        check("pp count one", 64'(alu_ready[0]), 64'h1);
        step(); wb_ready[0] = 1'b1;
        step();

        // Flush with held entries and a concurrent push
        step(); wb_ready = 2'b00; push(0, 8, 32'h88); push(1, 20, 32'h200);
        step(); alu_valid = 2'b00; push(1, 21, 32'h210);
        step(); alu_valid = 2'b00; push(0, 7, 32'h77); flush = 1'b1;
        sample(); check("flush wb_valid", 64'(wb_valid), 64'h0);
        step(); flush = 1'b0; alu_valid = '0;
        sample();
        check("post-flush ready", 64'(alu_ready), 64'h3);
        check("post-flush empty", 64'(wb_valid), 64'h0);
        step(); wb_ready = 2'b11;
        repeat (3) step();

        // Lane 1 stalled full while lane 0 streams
        step(); wb_ready = 2'b00; push(1, 22, 32'h220);
        step(); push(1, 23, 32'h230);
        step(); alu_valid[1] = 1'b0;
        wb_ready = 2'b01;
        for (int i = 0; i < 10; i++) begin
            push(0, 10 + i, XL'(i * 7));
            sample();
            check("stream valid", 64'(wb_valid[0]), 64'h1);
            check("stream tag", 64'(wb_tid[0]), 64'(10 + i));
            check("stream ready", 64'(alu_ready[0]), 64'h1);
            step();
        end
        alu_valid = '0;
        sample();
        check("stalled lane head", 64'(wb_tid[1]), 64'd22);
        check("stalled lane full", 64'(alu_ready[1]), 64'h0);
        step(); wb_ready = 2'b11;
        repeat (3) step();

        // Randomized traffic with occasional flush and one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c == 1500) rst_n = 1'b0;
            if (c == 1503) rst_n = 1'b1;
            flush    = ($urandom_range(31) == 0);
            wb_ready = NR'($urandom);
            for (int l = 0; l < NR; l++) begin
                alu_valid[l] = model_ready(l) && ($urandom_range(3) != 0);
                alu_tid[l]   = TW'($urandom);
                alu_res[l]   = $urandom;
            end
        end
        step(); alu_valid = '0; flush = 1'b0; wb_ready = 2'b11;
        repeat (3) step();

`ifdef ALU_WB_SKID_PERF_EN
        rst_n = 1'b0;
        step(); rst_n = 1'b1; wb_ready = 2'b00;
        step(); push(0, 9, 32'h99);
        step(); alu_valid = '0;
        step();
        step();
        step(); wb_ready = 2'b11;
        sample();
        check("stall lane0", 64'(stall_cnt[0]), 64'd4);
        check("stall lane1", 64'(stall_cnt[1]), 64'd0);
        step(); rst_n = 1'b0;
        #1;
        check("stall reset lane0", 64'(stall_cnt[0]), 64'd0);
        check("stall reset lane1", 64'(stall_cnt[1]), 64'd0);
        step(); rst_n = 1'b1;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
